// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite widths, response codes, payload types and slave FSM states.
package axi_lite_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 8;
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int BUFFER_SIZE = 4096;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [1:0]            resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP
  } state_type;

  // Full-width compare so addresses above the array never alias onto it.
  function automatic logic addr_in_range(input addr_t addr, input int unsigned depth);
    return addr < addr_t'(depth);
  endfunction

endpackage

// File: rtl/axi_lite_slave_ram.sv
// Byte-wide storage with synchronous write and combinational read on a shared index.
// Contents have no reset and survive a slave reset.
module axi_lite_slave_ram
  import axi_lite_pkg::*;
#(
  parameter int unsigned DEPTH = BUFFER_SIZE,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  data_t            wdata,
  output data_t            rdata
);

  data_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite byte memory slave, one transaction at a time with reads winning ties; AR->R 2 cycles, AW->B 3.
// Responses hold until rready/bready; optional AXI_LITE_SLAVE_MEM_WSTRB_EN gates writes on wstrb[0].
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int unsigned DEPTH = BUFFER_SIZE
) (
  input  logic  clock,
  input  logic  reset,
  input  addr_t araddr,
  input  logic  arvalid,
  output logic  arready,
  output data_t rdata,
  output resp_t rresp,
  output logic  rvalid,
  input  logic  rready,
  input  addr_t awaddr,
  input  logic  awvalid,
  output logic  awready,
  input  data_t wdata,
  input  strb_t wstrb,
  input  logic  wvalid,
  output logic  wready,
  output resp_t bresp,
  output logic  bvalid,
  input  logic  bready
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_type        state_q, state_d;
  addr_t            addr_q, addr_d;
  data_t            rdata_q, rdata_d;
  resp_t            rresp_q, rresp_d;
  resp_t            bresp_q, bresp_d;
  logic [IDX_W-1:0] ram_idx;
  data_t            ram_rdata;
  logic             ram_we;
  logic             wr_allow;

`ifdef AXI_LITE_SLAVE_MEM_WSTRB_EN
  assign wr_allow = wstrb[0];
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
  assign wr_allow     = 1'b1;
`endif

  // Reads look up the live AR address so data lands in the same cycle as the handshake.
  assign ram_idx = (state_q == RADDR) ? araddr[IDX_W-1:0] : addr_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    bresp_d = bresp_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arvalid) begin
          state_d = RADDR;
        end else if (awvalid) begin
          state_d = WADDR;
        end
      end
      RADDR: begin
        if (arvalid) begin
          addr_d = araddr;
          if (addr_in_range(araddr, DEPTH)) begin
            rdata_d = ram_rdata;
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (rready) begin
          state_d = IDLE;
        end
      end
      WADDR: begin
        if (awvalid) begin
          addr_d  = awaddr;
          state_d = WDATA;
        end
      end
      WDATA: begin
        if (wvalid) begin
          if (addr_in_range(addr_q, DEPTH)) begin
            ram_we  = wr_allow;
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
    end
  end

  // A reset landing on the write edge discards the pending write.
  axi_lite_slave_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we && !reset),
    .idx   (ram_idx),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  assign arready = (state_q == RADDR);
  assign rvalid  = (state_q == RDATA);
  assign awready = (state_q == WADDR);
  assign wready  = (state_q == WDATA);
  assign bvalid  = (state_q == WRESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem; expected R/B responses are queued and checked by a monitor.
module tb_axi_lite_slave_mem;
  import axi_lite_pkg::*;

  localparam int TMO = 50;

  logic  clock;
  logic  reset;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;
  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;

  typedef struct {
    logic  is_b;
    data_t data;
    resp_t resp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  axi_lite_slave_mem dut (
    .clock   (clock),
    .reset   (reset),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_r(input data_t d, input resp_t r);
    sb_q.push_back('{1'b0, d, r});
  endtask

  task automatic expect_b(input resp_t r);
    sb_q.push_back('{1'b1, 8'h00, r});
  endtask

  // Monitor: compare every completed R or B handshake against the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      if (rvalid && rready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_r got rdata %0h with empty queue", rdata);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_kind_r", {31'd0, mon_e.is_b}, 32'd0);
          chk("sb_rdata", {24'd0, rdata}, {24'd0, mon_e.data});
          chk("sb_rresp", {30'd0, rresp}, {30'd0, mon_e.resp});
        end
      end
      if (bvalid && bready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_b got bresp %0h with empty queue", bresp);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_kind_b", {31'd0, mon_e.is_b}, 32'd1);
          chk("sb_bresp", {30'd0, bresp}, {30'd0, mon_e.resp});
        end
      end
    end
  end

  task automatic do_read(input addr_t a, input data_t d, input int hold);
    int n;
    araddr  = a;
    arvalid = 1'b1;
    if (hold > 0) rready = 1'b0;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!arready && n < TMO);
    chk("ar_latency", n, 1);
    @(posedge clock); #1;
    arvalid = 1'b0;
    chk("rvalid_up", {31'd0, rvalid}, 32'd1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        chk("hold_rvalid", {31'd0, rvalid}, 32'd1);
        chk("hold_rdata", {24'd0, rdata}, {24'd0, d});
        chk("hold_arready", {31'd0, arready}, 32'd0);
      end
      rready = 1'b1;
    end
    @(posedge clock); #1;
    chk("r_done", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic do_write(input addr_t a, input data_t d, input strb_t s, input int exp_lat);
    int n;
    awaddr  = a;
    awvalid = 1'b1;
    wdata   = d;
    wstrb   = s;
    wvalid  = 1'b1;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!awready && n < TMO);
    chk("aw_latency", n, exp_lat);
    @(posedge clock); #1;
    awvalid = 1'b0;
    chk("wready_up", {31'd0, wready}, 32'd1);
    @(posedge clock); #1;
    wvalid = 1'b0;
    chk("bvalid_up", {31'd0, bvalid}, 32'd1);
    @(posedge clock); #1;
    chk("b_done", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_arready"}, {31'd0, arready}, 32'd0);
    chk({tag, "_awready"}, {31'd0, awready}, 32'd0);
    chk({tag, "_wready"}, {31'd0, wready}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd0);
    chk({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
    chk({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
    chk({tag, "_bresp"}, {30'd0, bresp}, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // In-range write then read.
    expect_b(RESP_OKAY);
    do_write(32'h4, 8'hA5, 1'b1, 1);
    expect_r(8'hA5, RESP_OKAY);
    do_read(32'h4, 8'hA5, 0);

    // Out of range must not alias onto index 0.
    expect_b(RESP_OKAY);
    do_write(32'h0, 8'h11, 1'b1, 1);
    expect_b(RESP_SLVERR);
    do_write(32'h1000, 8'h3C, 1'b1, 1);
    expect_r(8'h00, RESP_SLVERR);
    do_read(32'h1000, 8'h00, 0);
    expect_r(8'h11, RESP_OKAY);
    do_read(32'h0, 8'h11, 0);

    // Top valid address.
    expect_b(RESP_OKAY);
    do_write(32'hFFF, 8'h77, 1'b1, 1);
    expect_r(8'h77, RESP_OKAY);
    do_read(32'hFFF, 8'h77, 0);

    // Simultaneous AR and AW: read first with old data, write served after.
    expect_r(8'hA5, RESP_OKAY);
    expect_b(RESP_OKAY);
    fork
      do_read(32'h4, 8'hA5, 0);
      do_write(32'h14, 8'h5A, 1'b1, 4);
    join
    expect_r(8'h5A, RESP_OKAY);
    do_read(32'h14, 8'h5A, 0);

    // Read backpressure for 10 cycles.
    expect_r(8'h5A, RESP_OKAY);
    do_read(32'h14, 8'h5A, 10);

    // Reset while in WDATA with wvalid high.
    awaddr  = 32'h14;
    awvalid = 1'b1;
    wdata   = 8'h99;
    wstrb   = 1'b1;
    wvalid  = 1'b1;
    @(posedge clock); #1;
    chk("rst_awready", {31'd0, awready}, 32'd1);
    @(posedge clock); #1;
    awvalid = 1'b0;
    chk("rst_wready", {31'd0, wready}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_idle_outputs("midwr");
    reset  = 1'b0;
    wvalid = 1'b0;
    @(posedge clock); #1;
    expect_r(8'h5A, RESP_OKAY);
    do_read(32'h14, 8'h5A, 0);

    // Zero strobe write.
    expect_b(RESP_OKAY);
    do_write(32'h4, 8'hFF, 1'b0, 1);
`ifdef AXI_LITE_SLAVE_MEM_WSTRB_EN
    expect_r(8'hA5, RESP_OKAY);
    do_read(32'h4, 8'hA5, 0);
`else
    expect_r(8'hFF, RESP_OKAY);
    do_read(32'h4, 8'hFF, 0);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- AXI4-Lite memory slave sitting directly downstream of the interconnect master port.
- Consumes AR/R/AW/W/B traffic produced by the interconnect/driver and backs it with a byte-wide storage array of BUFFER_SIZE entries.
- Serves as the DUT-side endpoint the monitor and scoreboard check against.
- Handles one transaction at a time: reads have priority, writes are serialised.

Parameters:
- ADDR_WIDTH, 32, address width (from axi_lite_pkg).
- DATA_WIDTH, 8, data width; STRB_WIDTH = DATA_WIDTH/8.
- DEPTH, BUFFER_SIZE (4096), number of addressable bytes; byte address range 0..DEPTH-1.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  STRB_WIDTH  write strobe.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset (sampled high at a clock edge):
  - State goes to IDLE.
  - arready, awready, wready, rvalid and bvalid go to 0.
  - rdata = 0; rresp = bresp = RESP_OKAY.
  - Storage contents are NOT cleared.
- FSM uses state_type: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP. Ready/valid outputs are decoded from the registered state. rdata/rresp/bresp are registered.
- IDLE: all readies/valids 0.
  - arvalid=1 -> RADDR.
  - else awvalid=1 -> WADDR.
  - Both valid in the same cycle: read wins; awvalid stays pending and is served after the read completes.
- RADDR:
  - arready=1.
  - On arvalid&arready: latch araddr; load rdata/rresp from storage; -> RDATA.
- RDATA:
  - rvalid=1; rdata/rresp held stable until rready.
  - On rvalid&rready -> IDLE.
- WADDR:
  - awready=1.
  - On handshake: latch awaddr -> WDATA.
- WDATA:
  - wready=1.
  - On wvalid&wready: perform write if the address is in range; set bresp; -> WRESP.
- WRESP:
  - bvalid=1.
  - On bvalid&bready -> IDLE.
- Minimum latencies:
  - arvalid rising at cycle 0 -> arready at cycle 1 -> rvalid at cycle 2.
  - awvalid at cycle 0 -> awready at 1 -> wready at 2 -> bvalid at 3 (wvalid already high).
- Back-to-back: at least one IDLE cycle between transactions.
- Address decode: byte address, full-width compare.
  - addr < DEPTH -> RESP_OKAY, index = addr.
  - addr >= DEPTH -> RESP_SLVERR. Reads return rdata=0; writes are suppressed, no storage change.
- Boundaries:
  - addr DEPTH-1 is valid; addr DEPTH errors. There is no wrap-around.
  - rready or bready held low: the response is held indefinitely and no new address is accepted.
  - Reset asserted in any state: the next edge enters IDLE, and any pending write in WDATA is discarded.
- RESP_EXOKAY and RESP_DECERR are never generated.

Optional Feature:
- Macro: AXI_LITE_SLAVE_MEM_WSTRB_EN.
- Defined:
  - A byte is written only if wstrb[0]=1.
  - wstrb=0 in range: no write, bresp=RESP_OKAY.
- Undefined:
  - wstrb is ignored; every in-range write updates storage.

Decomposition:
- Shared package axi_lite_pkg holds: ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH, RESP_* constants, addr_t/data_t/strb_t/resp_t, state_type, BUFFER_SIZE.
- One sub-module: axi_lite_slave_ram.
  - Byte array of DEPTH entries.
  - Synchronous write with enable.
  - Combinational read on the index.
  - Instantiated once.

Test Plan:
- Write then read, in range: write 0xA5 to addr 0x4 -> bresp=OKAY; read 0x4 -> rdata=0xA5, rresp=OKAY.
- Out of range: write 0x3C to 0x1000 -> bresp=SLVERR, no array change; read 0x1000 -> rdata=0x00, rresp=SLVERR.
- Edge address: write 0x77 to 0xFFF -> OKAY; read 0xFFF -> 0x77.
- Simultaneous requests: arvalid(0x4) and awvalid(0x14, data 0x5A) asserted in the same cycle -> read completes first, returning the old 0x4 data; the write then completes; read 0x14 -> 0x5A.
- Backpressure: hold rready=0 for 10 cycles -> rvalid stays 1, rdata stable, arready stays 0; release -> IDLE on the next edge.
- Reset mid-write: assert reset while in WDATA with wvalid=1 -> next edge all outputs 0, state IDLE; addr 0x14 keeps its prior value.
- Strobe (only with AXI_LITE_SLAVE_MEM_WSTRB_EN defined): wstrb=0 write of 0xFF to 0x4 -> bresp=OKAY; 0x4 is unchanged.
